// File: rtl/gates_pkg.sv
// Shared types and sizing helpers for the two-requester mux arbiter.
package gates_pkg;

    typedef enum logic {
        GRANT_IN2 = 1'b0,
        GRANT_IN1 = 1'b1
    } grant_e;

    // Ceiling log2, used at elaboration to size the burst counter.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        int unsigned v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/Mux2.sv
// Plain 2:1 datapath mux; sel=1 picks d1.
module Mux2 #(
    parameter int unsigned WIDTH = 8
) (
    input  logic [WIDTH-1:0] d1,
    input  logic [WIDTH-1:0] d0,
    input  logic             sel,
    output logic [WIDTH-1:0] y
);

    assign y = sel ? d1 : d0;

endmodule

// File: rtl/mux2_rr_arbiter.sv
// Round-robin arbiter with bounded bursts sharing one Mux2 between two
// valid/ready requesters, feeding a one-entry registered output stage.
module mux2_rr_arbiter
    import gates_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned BURST = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    input  logic             in2_valid,
    input  logic [WIDTH-1:0] in2_data,
    output logic             in2_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             grant1
);

    localparam int unsigned      CNT_W   = clog2(BURST + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(BURST);

    grant_e           owner;
    grant_e           owner_nxt;
    grant_e           grant;
    grant_e           other;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;
    logic             accept;
    logic             xfer1;
    logic             xfer2;
    logic             xfer;
    logic [WIDTH-1:0] mux_data;

    Mux2 #(
        .WIDTH(WIDTH)
    ) u_mux (
        .d1 (in1_data),
        .d0 (in2_data),
        .sel(grant1),
        .y  (mux_data)
    );

    // Owner/burst-count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            owner <= GRANT_IN2;
            cnt   <= '0;
        end else begin
            owner <= owner_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // Grant selection and owner/count update; cnt==0 means no burst in
    // progress (fresh out of reset), so contention goes to the non-owner, in1.
    always_comb begin
        owner_nxt = owner;
        cnt_nxt   = cnt;
        other     = (owner == GRANT_IN1) ? GRANT_IN2 : GRANT_IN1;
        grant     = owner;

        if (in1_valid && in2_valid) begin
            grant = ((cnt != '0) && (cnt < CNT_MAX)) ? owner : other;
        end else if (in1_valid) begin
            grant = GRANT_IN1;
        end else if (in2_valid) begin
            grant = GRANT_IN2;
        end

        accept = ~out_valid | out_ready;
        xfer1  = accept & in1_valid & (grant == GRANT_IN1) & ~rst;
        xfer2  = accept & in2_valid & (grant == GRANT_IN2) & ~rst;
        xfer   = xfer1 | xfer2;

        if (xfer) begin
            if (grant == owner) begin
                cnt_nxt = (cnt == CNT_MAX) ? cnt : cnt + CNT_W'(1);
            end else begin
                owner_nxt = grant;
                cnt_nxt   = CNT_W'(1);
            end
        end
    end

    assign grant1    = (grant == GRANT_IN1);
    assign in1_ready = xfer1;
    assign in2_ready = xfer2;

    // One-entry output stage.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (xfer) begin
            out_valid <= 1'b1;
            out_data  <= mux_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Scoreboard bench for mux2_rr_arbiter: directed scenarios then random traffic.
module tb_mux2_rr_arbiter;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned BURST = 2;

    logic             clk;
    logic             rst;
    logic             in1_valid;
    logic [WIDTH-1:0] in1_data;
    logic             in1_ready;
    logic             in2_valid;
    logic [WIDTH-1:0] in2_data;
    logic             in2_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_ready;
    logic             grant1;

    int tests  = 0;
    int errors = 0;

    // Reference state: who got the last grant (0 = nobody since reset) and
    // how many consecutive grants that requester has had (saturating).
    int last = 0;
    int run  = 0;
    logic [WIDTH-1:0] sb[$];

    logic [WIDTH-1:0] d1 = '0;
    logic [WIDTH-1:0] d2 = '0;
    logic [WIDTH-1:0] next1 = 8'hA1;
    logic [WIDTH-1:0] next2 = 8'hB1;
    bit have1 = 0;
    bit have2 = 0;

    mux2_rr_arbiter #(
        .WIDTH(WIDTH),
        .BURST(BURST)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in1_valid(in1_valid),
        .in1_data (in1_data),
        .in1_ready(in1_ready),
        .in2_valid(in2_valid),
        .in2_data (in2_data),
        .in2_ready(in2_ready),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .grant1   (grant1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of traffic; want1/want2 request valid, data comes from the
    // per-requester counters or $urandom and is held until accepted.
    task automatic step(input bit want1, input bit want2, input bit ordy, input bit rnd);
        int g;
        bit acc;
        bit r1;
        bit r2;
        @(negedge clk);
        rst = 1'b0;
        if (want1 && !have1) begin
            have1 = 1;
            d1    = rnd ? WIDTH'($urandom) : next1;
            next1 = next1 + 8'd1;
        end
        if (want2 && !have2) begin
            have2 = 1;
            d2    = rnd ? WIDTH'($urandom) : next2;
            next2 = next2 + 8'd1;
        end
        in1_valid = want1;
        in1_data  = d1;
        in2_valid = want2;
        in2_data  = d2;
        out_ready = ordy;
        #1;
        acc = (sb.size() == 0) || ordy;
        if (want1 && want2) begin
            if (last == 0)         g = 1;
            else if (run < BURST)  g = last;
            else                   g = 3 - last;
        end else if (want1) begin
            g = 1;
        end else if (want2) begin
            g = 2;
        end else begin
            g = (last == 1) ? 1 : 2;
        end
        r1 = acc && want1 && (g == 1);
        r2 = acc && want2 && (g == 2);
        check("grant1", 32'(grant1), 32'(g == 1));
        check("in1_ready", 32'(in1_ready), 32'(r1));
        check("in2_ready", 32'(in2_ready), 32'(r2));
        @(posedge clk);
        if (r1 || r2) begin
            sb.push_back(r1 ? d1 : d2);
            if (r1) have1 = 0;
            else    have2 = 0;
            if (g == last) begin
                if (run < BURST) run++;
            end else begin
                last = g;
                run  = 1;
            end
        end
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst       = 1'b1;
            in1_valid = 1'b1;
            in1_data  = 8'hEE;
            in2_valid = 1'b0;
            out_ready = 1'b0;
            #1;
            check("rst_in1_ready", 32'(in1_ready), 32'd0);
            check("rst_in2_ready", 32'(in2_ready), 32'd0);
            @(posedge clk);
            sb.delete();
            last = 0;
            run  = 0;
        end
        #1;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
    endtask

    // Monitor: output stage occupancy and in-order data on each handshake.
    initial begin
        logic [WIDTH-1:0] exp;
        forever begin
            @(negedge clk);
            #3;
            if (!rst) begin
                check("out_valid", 32'(out_valid), 32'(sb.size() != 0));
                if (out_valid && out_ready) begin
                    if (sb.size() == 0) begin
                        check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
                    end else begin
                        exp = sb.pop_front();
                        check("out_data", 32'(out_data), 32'(exp));
                    end
                end
            end
        end
    end

    initial begin
        rst       = 1'b1;
        in1_valid = 1'b0;
        in1_data  = '0;
        in2_valid = 1'b0;
        in2_data  = '0;
        out_ready = 1'b0;

        do_reset(2);

        // Both streaming at full rate: A1,A2,B1,B2,A3,A4...
        for (int i = 0; i < 8; i++) step(1, 1, 1, 0);
        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);

        // Lone in2 streams 0x10..0x14 with the burst count saturated.
        have2 = 0;
        next2 = 8'h10;
        for (int i = 0; i < 5; i++) step(0, 1, 1, 0);
        step(0, 0, 1, 0);

        // Stall holding 0x55, then release.
        have1 = 0;
        next1 = 8'h55;
        step(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            step(1, 1, 0, 0);
            check("stall_data", 32'(out_data), 32'h55);
        end
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);
        for (int i = 0; i < 2; i++) step(0, 0, 1, 0);

        // in1 owns with cnt=1, drops valid; waiting in2 granted at once.
        do_reset(1);
        have1 = 0;
        have2 = 0;
        step(1, 0, 1, 0);
        next2 = 8'h77;
        step(0, 1, 1, 0);
        step(0, 0, 1, 0);

        // Reset right after an in2 grant drops the held word.
        step(0, 1, 0, 0);
        do_reset(1);
        for (int i = 0; i < 4; i++) step(1, 1, 1, 0);

        // Random traffic with occasional resets.
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) == 0) do_reset(1);
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0,
                 $urandom_range(0, 3) != 0, 1);
        end

        for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
        check("sb_empty", 32'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end

endmodule
